image_frame_writer: RTL and testbench

IMAGE_FRAME_WRITER -- requirements
Module: image_frame_writer

---
 rtl/image_frame_writer_pkg.sv | 43 ++++
 rtl/image_frame_writer_if.sv | 37 +++
 rtl/image_frame_writer_rgb565_byte_packer.sv | 50 +++++
 rtl/image_frame_writer.sv | 134 +++++++++++++
 tb/tb_image_frame_writer.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/image_frame_writer_pkg.sv
// ---------------------------------------------------------------------------
// image_frame_writer_pkg
// Shared definitions for the image frame writer:
//   - state_t       : capture FSM state encoding
//   - DEFAULT_NUM_PIXELS : default number of pixels per frame
//   - RGB565 field positions (R 15:11, G 10:5, B 4:0)
//   - pack_bytes / rgb565_pack helpers used to build 16-bit pixels
// ---------------------------------------------------------------------------
package image_frame_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HI_BYTE = 2'd1,
        ST_LO_BYTE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int DEFAULT_NUM_PIXELS = 256;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    // The byte stream is high byte first, so the first byte lands on top.
    function automatic logic [15:0] pack_bytes(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

    function automatic logic [15:0] rgb565_pack(input logic [4:0] r,
                                                input logic [5:0] g,
                                                input logic [4:0] b);
        logic [15:0] p;
        p = '0;
        p[R_MSB:R_LSB] = r;
        p[G_MSB:G_LSB] = g;
        p[B_MSB:B_LSB] = b;
        return p;
    endfunction

endpackage

// File: rtl/image_frame_writer_if.sv
// ---------------------------------------------------------------------------
// image_frame_writer_if
// Bundles the control, byte-stream and memory-write signals of the frame
// writer.
//   start, abort          : frame control from the environment
//   byte_valid, byte_data : RGB565 byte stream in, high byte first
//   byte_ready            : writer accepts a byte this cycle
//   wr_en, wr_addr, wr_data : one-cycle write port to the image memory
//   busy, frame_done      : frame status
// Modports:
//   master : the frame writer itself
//   slave  : the environment (byte source, controller, image memory)
// ---------------------------------------------------------------------------
interface image_frame_writer_if #(
    parameter int ADDR_W = 16
);
    logic              start;
    logic              abort;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic              busy;
    logic              frame_done;

    modport master (
        input  start, abort, byte_valid, byte_data,
        output byte_ready, wr_en, wr_addr, wr_data, busy, frame_done
    );

    modport slave (
        output start, abort, byte_valid, byte_data,
        input  byte_ready, wr_en, wr_addr, wr_data, busy, frame_done
    );
endinterface

// File: rtl/image_frame_writer_rgb565_byte_packer.sv
// ---------------------------------------------------------------------------
// rgb565_byte_packer
// Assembles two stream bytes into one RGB565 pixel and raises a one-cycle
// pixel-valid strobe the cycle after the low byte arrives.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   clear        : drops any half-assembled pixel and suppresses the strobe
//   hi_load      : capture byte_data as the high byte
//   lo_load      : combine held high byte with byte_data into a pixel
//   byte_data    : incoming stream byte
//   pixel        : assembled RGB565 pixel
//   pixel_valid  : high for one cycle when pixel holds a fresh value
// ---------------------------------------------------------------------------
module rgb565_byte_packer
    import image_frame_writer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        hi_load,
    input  logic        lo_load,
    input  logic [7:0]  byte_data,
    output logic [15:0] pixel,
    output logic        pixel_valid
);

    logic [7:0] hi_byte;

    // The strobe is re-evaluated every cycle so it can never stretch, and a
    // clear wipes the held high byte so a half pixel never leaks into the
    // next frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_byte     <= '0;
            pixel       <= '0;
            pixel_valid <= 1'b0;
        end else begin
            pixel_valid <= lo_load && !clear;
            if (clear) begin
                hi_byte <= '0;
            end else if (hi_load) begin
                hi_byte <= byte_data;
            end
            if (lo_load && !clear) begin
                pixel <= pack_bytes(hi_byte, byte_data);
            end
        end
    end

endmodule

// File: rtl/image_frame_writer.sv
// ---------------------------------------------------------------------------
// image_frame_writer
// Captures one frame of NUM_PIXELS RGB565 pixels from a byte stream (high
// byte first) and writes them to an image memory at addresses
// 0..NUM_PIXELS-1, one write per pixel.
// Ports:
//   clk   : sole clock
//   rst_n : synchronous active-low reset
//   bus   : image_frame_writer_if.master (start/abort control, byte stream,
//           memory write port, busy/frame_done status)
// Parameters:
//   NUM_PIXELS : pixels per frame (2..65536)
//   ADDR_W     : pixel address width
// ---------------------------------------------------------------------------
module image_frame_writer
    import image_frame_writer_pkg::*;
#(
    parameter int NUM_PIXELS = DEFAULT_NUM_PIXELS,
    parameter int ADDR_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    image_frame_writer_if.master bus
);

    // The counter carries one extra bit so a full 2^ADDR_W frame does not
    // wrap before the last-pixel comparison.
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NUM_PIXELS - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W:0]   pix_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              byte_ready;
    logic              busy;
    logic              frame_done;
    logic              xfer;
    logic              hi_take;
    logic              lo_take;
    logic              start_take;
    logic [15:0]       pixel;
    logic              pixel_valid;

    // Abort always wins, so no byte is consumed and no start is honoured in
    // a cycle where abort is high.
    assign xfer       = bus.byte_valid && byte_ready;
    assign hi_take    = (state == ST_HI_BYTE) && xfer && !bus.abort;
    assign lo_take    = (state == ST_LO_BYTE) && xfer && !bus.abort;
    assign start_take = (state == ST_IDLE) && bus.start && !bus.abort;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Moore outputs. frame_done is masked by abort so an
    // aborted DONE cycle does not report a completed frame.
    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_take) begin
                    state_next = ST_HI_BYTE;
                end
            end
            ST_HI_BYTE: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (bus.abort) begin
                    state_next = ST_IDLE;
                end else if (xfer) begin
                    state_next = ST_LO_BYTE;
                end
            end
            ST_LO_BYTE: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (bus.abort) begin
                    state_next = ST_IDLE;
                end else if (xfer) begin
                    state_next = (pix_cnt == LAST_IDX) ? ST_DONE : ST_HI_BYTE;
                end
            end
            ST_DONE: begin
                busy       = 1'b1;
                frame_done = !bus.abort;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Pixel counter and write address. The address is captured before the
    // increment so it lines up with the pixel the packer emits next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_cnt <= '0;
            addr_q  <= '0;
        end else if (start_take) begin
            pix_cnt <= '0;
        end else if (lo_take) begin
            addr_q  <= pix_cnt[ADDR_W-1:0];
            pix_cnt <= pix_cnt + (ADDR_W+1)'(1);
        end
    end

    rgb565_byte_packer u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (bus.abort),
        .hi_load     (hi_take),
        .lo_load     (lo_take),
        .byte_data   (bus.byte_data),
        .pixel       (pixel),
        .pixel_valid (pixel_valid)
    );

    assign bus.byte_ready = byte_ready;
    assign bus.busy       = busy;
    assign bus.frame_done = frame_done;
    assign bus.wr_en      = pixel_valid;
    assign bus.wr_addr    = addr_q;
    assign bus.wr_data    = pixel;

endmodule

// File: tb/tb_image_frame_writer.sv
// ---------------------------------------------------------------------------
// tb_image_frame_writer
// Self-checking bench for image_frame_writer. Two instances share the clock
// and reset: dut4 (NUM_PIXELS=4) for the directed scenarios and dut256
// (default size) for a random full frame. Monitors collect every memory
// write; the expected frame is rebuilt from the byte list alone.
// ---------------------------------------------------------------------------
module tb_image_frame_writer;
    import image_frame_writer_pkg::*;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    image_frame_writer_if #(.ADDR_W(16)) bus4();
    image_frame_writer_if #(.ADDR_W(16)) bus256();

    image_frame_writer #(.NUM_PIXELS(4), .ADDR_W(16)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    image_frame_writer #(.NUM_PIXELS(256), .ADDR_W(16)) dut256 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus256)
    );

    // 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Write monitors: index 0 is dut4, index 1 is dut256.
    logic        mon_en;
    logic [31:0] wr_q4[$];
    logic [31:0] wr_q256[$];
    int          done_cnt[2];
    logic        done_wr[2];
    logic [15:0] done_addr[2];
    logic        busy_after[2];
    logic        prev_done[2];

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus4.wr_en === 1'b1) begin
                wr_q4.push_back({bus4.wr_addr, bus4.wr_data});
                checks++;
                assert (bus4.wr_addr < 16'd4) else begin
                    errors++;
                    $error("[TB] FAIL addr_range4 observed %0d expected below 4", bus4.wr_addr);
                end
            end
            if (prev_done[0]) busy_after[0] = bus4.busy;
            prev_done[0] = (bus4.frame_done === 1'b1);
            if (bus4.frame_done === 1'b1) begin
                done_cnt[0]++;
                done_wr[0]   = bus4.wr_en;
                done_addr[0] = bus4.wr_addr;
            end

            if (bus256.wr_en === 1'b1) begin
                wr_q256.push_back({bus256.wr_addr, bus256.wr_data});
            end
            if (prev_done[1]) busy_after[1] = bus256.busy;
            prev_done[1] = (bus256.frame_done === 1'b1);
            if (bus256.frame_done === 1'b1) begin
                done_cnt[1]++;
                done_wr[1]   = bus256.wr_en;
                done_addr[1] = bus256.wr_addr;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int sel, input logic start, input logic abort);
        if (sel == 0) begin
            bus4.start = start;
            bus4.abort = abort;
        end else begin
            bus256.start = start;
            bus256.abort = abort;
        end
    endtask

    task automatic driveSrc(input int sel, input logic valid, input logic [7:0] data);
        if (sel == 0) begin
            bus4.byte_valid = valid;
            bus4.byte_data  = data;
        end else begin
            bus256.byte_valid = valid;
            bus256.byte_data  = data;
        end
    endtask

    function automatic logic readReady(input int sel);
        return (sel == 0) ? bus4.byte_ready : bus256.byte_ready;
    endfunction

    function automatic logic [31:0] getWrite(input int sel, input int idx);
        if (sel == 0) return (idx < wr_q4.size()) ? wr_q4[idx] : 32'hDEAD_BEEF;
        return (idx < wr_q256.size()) ? wr_q256[idx] : 32'hDEAD_BEEF;
    endfunction

    task automatic clearMon(input int sel);
        if (sel == 0) wr_q4.delete();
        else          wr_q256.delete();
        done_cnt[sel]   = 0;
        done_wr[sel]    = 1'b0;
        done_addr[sel]  = 16'hFFFF;
        busy_after[sel] = 1'b1;
    endtask

    task automatic startFrame(input int sel);
        applyStimulus(sel, 1'b1, 1'b0);
        tick();
        applyStimulus(sel, 1'b0, 1'b0);
    endtask

    // Presents bytes in order; a byte counts as taken when valid and ready
    // were both high at the edge. mode 0: every cycle, 1: valid toggles,
    // 2: random gaps.
    task automatic streamBytes(input int sel, input logic [7:0] bytes[$], input int mode);
        int   idx;
        int   cyc;
        logic valid;
        logic rdy;
        idx = 0;
        cyc = 0;
        while (idx < bytes.size()) begin
            if (cyc > 3000) begin
                checks++;
                errors++;
                $error("[TB] FAIL stream_timeout observed %0d bytes expected %0d", idx, bytes.size());
                break;
            end
            case (mode)
                1:       valid = (cyc % 2) == 0;
                2:       valid = $urandom_range(0, 3) != 0;
                default: valid = 1'b1;
            endcase
            driveSrc(sel, valid, valid ? bytes[idx] : 8'($urandom_range(0, 255)));
            @(negedge clk);
            rdy = readReady(sel);
            tick();
            if (valid && rdy) idx++;
            cyc++;
        end
        driveSrc(sel, 1'b0, 8'h00);
    endtask

    // Expected frame: pixel i sits at address i and is high byte * 256 + low byte.
    task automatic checkFrame(input string tag, input int sel, input logic [7:0] bytes[$], input int npix);
        int got;
        logic [31:0] exp_word;
        got = (sel == 0) ? wr_q4.size() : wr_q256.size();
        checkOutput({tag, "_count"}, got, npix);
        for (int i = 0; i < npix; i++) begin
            exp_word = (32'(i) << 16) + 32'(bytes[2*i]) * 256 + 32'(bytes[2*i+1]);
            checkOutput($sformatf("%s_pix%0d", tag, i), getWrite(sel, i), exp_word);
        end
        checkOutput({tag, "_done_cnt"}, done_cnt[sel], 1);
        checkOutput({tag, "_done_with_wr"}, 32'(done_wr[sel]), 1);
        checkOutput({tag, "_done_addr"}, 32'(done_addr[sel]), npix - 1);
        checkOutput({tag, "_busy_after_done"}, 32'(busy_after[sel]), 0);
    endtask

    logic [7:0] frame_a[$];
    logic [7:0] rnd_bytes[$];

    initial begin
        checks = 0;
        errors = 0;
        mon_en = 1'b0;
        prev_done[0] = 1'b0;
        prev_done[1] = 1'b0;
        clearMon(0);
        clearMon(1);
        frame_a = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF};

        $display("[TB] reset");
        rst_n = 1'b0;
        applyStimulus(0, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 1'b0);
        driveSrc(0, 1'b0, 8'h00);
        driveSrc(1, 1'b0, 8'h00);
        tick();
        mon_en = 1'b1;
        tick();
        @(negedge clk);
        checkOutput("rst_wr_en",      32'(bus4.wr_en), 0);
        checkOutput("rst_byte_ready", 32'(bus4.byte_ready), 0);
        checkOutput("rst_busy",       32'(bus4.busy), 0);
        checkOutput("rst_frame_done", 32'(bus4.frame_done), 0);
        checkOutput("rst_wr_addr",    32'(bus4.wr_addr), 0);
        checkOutput("rst_wr_data",    32'(bus4.wr_data), 0);
        checkOutput("rst_wr_en_256",  32'(bus256.wr_en), 0);
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        checkOutput("idle_byte_ready", 32'(bus4.byte_ready), 0);
        checkOutput("idle_busy",       32'(bus4.busy), 0);
        tick();

        $display("[TB] basic 4-pixel frame");
        clearMon(0);
        startFrame(0);
        @(negedge clk);
        checkOutput("start_busy",       32'(bus4.busy), 1);
        checkOutput("start_byte_ready", 32'(bus4.byte_ready), 1);
        tick();
        streamBytes(0, frame_a, 0);
        repeat (3) tick();
        checkFrame("basic", 0, frame_a, 4);

        $display("[TB] toggled byte_valid");
        clearMon(0);
        startFrame(0);
        streamBytes(0, frame_a, 1);
        repeat (3) tick();
        checkFrame("toggle", 0, frame_a, 4);

        $display("[TB] abort with a write pending");
        clearMon(0);
        startFrame(0);
        streamBytes(0, frame_a[0:3], 0);
        applyStimulus(0, 1'b0, 1'b1);
        tick();
        applyStimulus(0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("abort4_busy",       32'(bus4.busy), 0);
        checkOutput("abort4_byte_ready", 32'(bus4.byte_ready), 0);
        repeat (3) tick();
        checkOutput("abort4_count", wr_q4.size(), 2);
        checkOutput("abort4_w0",    getWrite(0, 0), 32'h0000_F800);
        checkOutput("abort4_w1",    getWrite(0, 1), 32'h0001_07E0);
        checkOutput("abort4_done",  done_cnt[0], 0);

        $display("[TB] abort with a half pixel");
        clearMon(0);
        startFrame(0);
        streamBytes(0, frame_a[0:2], 0);
        applyStimulus(0, 1'b0, 1'b1);
        tick();
        applyStimulus(0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("abort3_busy",       32'(bus4.busy), 0);
        checkOutput("abort3_byte_ready", 32'(bus4.byte_ready), 0);
        repeat (3) tick();
        checkOutput("abort3_count", wr_q4.size(), 1);
        checkOutput("abort3_w0",    getWrite(0, 0), 32'h0000_F800);
        checkOutput("abort3_done",  done_cnt[0], 0);
        clearMon(0);
        startFrame(0);
        streamBytes(0, frame_a, 0);
        repeat (3) tick();
        checkFrame("restart", 0, frame_a, 4);

        $display("[TB] start mid-frame and start with abort");
        clearMon(0);
        startFrame(0);
        streamBytes(0, frame_a[0:3], 0);
        applyStimulus(0, 1'b1, 1'b0);
        streamBytes(0, frame_a[4:7], 0);
        applyStimulus(0, 1'b0, 1'b0);
        repeat (3) tick();
        checkFrame("start_mid", 0, frame_a, 4);
        clearMon(0);
        applyStimulus(0, 1'b1, 1'b1);
        tick();
        applyStimulus(0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("startabort_busy",       32'(bus4.busy), 0);
        checkOutput("startabort_byte_ready", 32'(bus4.byte_ready), 0);
        repeat (3) tick();
        checkOutput("startabort_later_busy", 32'(bus4.busy), 0);
        checkOutput("startabort_writes",     wr_q4.size(), 0);

        $display("[TB] reset mid-frame");
        clearMon(0);
        startFrame(0);
        streamBytes(0, frame_a[0:2], 0);
        rst_n = 1'b0;
        driveSrc(0, 1'b1, frame_a[3]);
        tick();
        @(negedge clk);
        checkOutput("midrst_wr_en",      32'(bus4.wr_en), 0);
        checkOutput("midrst_frame_done", 32'(bus4.frame_done), 0);
        checkOutput("midrst_busy",       32'(bus4.busy), 0);
        checkOutput("midrst_byte_ready", 32'(bus4.byte_ready), 0);
        checkOutput("midrst_wr_addr",    32'(bus4.wr_addr), 0);
        checkOutput("midrst_wr_data",    32'(bus4.wr_data), 0);
        rst_n = 1'b1;
        driveSrc(0, 1'b0, 8'h00);
        repeat (5) tick();
        checkOutput("midrst_writes", wr_q4.size(), 1);
        checkOutput("midrst_done",   done_cnt[0], 0);
        checkOutput("midrst_idle",   32'(bus4.busy), 0);

        $display("[TB] random 256-pixel frame");
        for (int i = 0; i < 512; i++) begin
            rnd_bytes.push_back(8'($urandom_range(0, 255)));
        end
        clearMon(1);
        startFrame(1);
        streamBytes(1, rnd_bytes, 2);
        repeat (3) tick();
        checkFrame("rand256", 1, rnd_bytes, 256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
